// File: rtl/ddr_route_mux_pkg.sv
// Shared types and default sizing for the DDR-to-loader route fabric.
// Descriptor layout follows the package widths below.
package ddr_route_mux_pkg;

    localparam int DDR_CH_DEF      = 2;
    localparam int LD_NUM_DEF      = 4;
    localparam int DDR_W_DEF       = 512;
    localparam int BEAT_W_DEF      = 16;
    localparam int ROUTE_DEPTH_DEF = 4;

    function automatic int bw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LD_W = bw(LD_NUM_DEF);

    typedef struct packed {
        logic [LD_W-1:0]       dst;
        logic [BEAT_W_DEF-1:0] beats;
    } route_desc_t;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_REQ    = 2'd1,
        CH_STREAM = 2'd2
    } ch_state_e;

endpackage

// File: rtl/ddr_route_ch.sv
// One DDR read channel: descriptor FIFO, IDLE/REQ/STREAM FSM and beat counter.
// ROUTE_PERF_EN builds the per-channel stall counter; otherwise perf_stall is 0.
module ddr_route_ch
    import ddr_route_mux_pkg::*;
#(
    parameter int LD_NUM      = LD_NUM_DEF,
    parameter int BEAT_W      = BEAT_W_DEF,
    parameter int ROUTE_DEPTH = ROUTE_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              route_valid,
    output logic              route_ready,
    input  logic [LD_W-1:0]   route_dst,
    input  logic [BEAT_W-1:0] route_beats,
    input  logic              ddr_valid,
    output logic              ddr_ready,
    input  logic              ld_ready_sel,
    output logic              lock_req,
    input  logic              lock_grant,
    output logic              lock_rel,
    output logic              done_req,
    output logic [LD_W-1:0]   cur_dst,
    output logic              ch_busy,
    output logic [31:0]       perf_stall
);

    localparam int            PW       = bw(ROUTE_DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(ROUTE_DEPTH);
    localparam logic [LD_W:0] LD_LIM   = (LD_W+1)'(LD_NUM);

    route_desc_t       mem [ROUTE_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       fill;
    logic              fifo_empty, push, pop, hs, last_beat, dst_ok;
    logic [BEAT_W-1:0] cnt;
    ch_state_e         state, state_nx;

    assign fifo_empty  = (fill == '0);
    assign route_ready = (fill != FULL_CNT);
    assign push        = route_valid && route_ready;
    assign ddr_ready   = (state == CH_STREAM) && ld_ready_sel;
    assign hs          = ddr_valid && ddr_ready;
    assign last_beat   = hs && (cnt == BEAT_W'(1));
    assign dst_ok      = {1'b0, cur_dst} < LD_LIM;
    assign ch_busy     = (state != CH_IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{dst: route_dst, beats: route_beats};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CH_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
            cnt     <= '0;
            cur_dst <= '0;
        end else begin
            state <= state_nx;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: ;
            endcase
            if (pop) begin
                cur_dst <= mem[rd_ptr].dst;
                cnt     <= mem[rd_ptr].beats;
            end else if (hs) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Zero-beat and out-of-range routes never touch a lock; only in-range ones report done.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        lock_req = 1'b0;
        lock_rel = 1'b0;
        done_req = 1'b0;
        case (state)
            CH_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = CH_REQ;
                end
            end
            CH_REQ: begin
                if (cnt == '0 || !dst_ok) begin
                    done_req = dst_ok;
                    state_nx = CH_IDLE;
                end else begin
                    lock_req = 1'b1;
                    if (lock_grant) state_nx = CH_STREAM;
                end
            end
            CH_STREAM: begin
                if (last_beat) begin
                    lock_rel = 1'b1;
                    done_req = 1'b1;
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        state_nx = CH_REQ;
                    end else begin
                        state_nx = CH_IDLE;
                    end
                end
            end
            default: state_nx = CH_IDLE;
        endcase
    end

`ifdef ROUTE_PERF_EN
    logic [31:0] stall_q;
    logic        stall_inc;

    assign stall_inc = (state == CH_REQ) ||
                       ((state == CH_STREAM) && ddr_valid && !ddr_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             stall_q <= '0;
        else if (stall_inc && stall_q != '1) stall_q <= stall_q + 1'b1;
    end

    assign perf_stall = stall_q;
`else
    assign perf_stall = '0;
`endif

endmodule

// File: rtl/ddr_route_mux.sv
// DDR read-channel to buffer-loader router: per-channel route engines, fixed-priority
// loader locks, loader-side data mux and registered done. Optional macro: ROUTE_PERF_EN.
module ddr_route_mux
    import ddr_route_mux_pkg::*;
#(
    parameter int DDR_CH      = DDR_CH_DEF,
    parameter int LD_NUM      = LD_NUM_DEF,
    parameter int DDR_W       = DDR_W_DEF,
    parameter int BEAT_W      = BEAT_W_DEF,
    parameter int ROUTE_DEPTH = ROUTE_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DDR_CH-1:0]              route_valid,
    output logic [DDR_CH-1:0]              route_ready,
    input  logic [DDR_CH-1:0][LD_W-1:0]    route_dst,
    input  logic [DDR_CH-1:0][BEAT_W-1:0]  route_beats,
    input  logic [DDR_CH-1:0][DDR_W-1:0]   ddr_data,
    input  logic [DDR_CH-1:0]              ddr_valid,
    output logic [DDR_CH-1:0]              ddr_ready,
    output logic [LD_NUM-1:0][DDR_W-1:0]   ld_data,
    output logic [LD_NUM-1:0]              ld_valid,
    input  logic [LD_NUM-1:0]              ld_ready,
    output logic [LD_NUM-1:0]              ld_done,
    output logic [DDR_CH-1:0]              ch_busy,
    output logic [DDR_CH-1:0][31:0]        perf_stall
);

    localparam int OWN_W = bw(DDR_CH);

    logic [DDR_CH-1:0]             lock_req, lock_grant, lock_rel, done_req, ld_ready_sel;
    logic [DDR_CH-1:0][LD_W-1:0]   cur_dst;
    logic [LD_NUM-1:0]             lock_busy, lock_taken, done_nx;
    logic [LD_NUM-1:0][OWN_W-1:0]  lock_owner;

    for (genvar c = 0; c < DDR_CH; c++) begin : g_ch
        assign ld_ready_sel[c] = ld_ready[cur_dst[c]];

        ddr_route_ch #(
            .LD_NUM      (LD_NUM),
            .BEAT_W      (BEAT_W),
            .ROUTE_DEPTH (ROUTE_DEPTH)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .route_valid  (route_valid[c]),
            .route_ready  (route_ready[c]),
            .route_dst    (route_dst[c]),
            .route_beats  (route_beats[c]),
            .ddr_valid    (ddr_valid[c]),
            .ddr_ready    (ddr_ready[c]),
            .ld_ready_sel (ld_ready_sel[c]),
            .lock_req     (lock_req[c]),
            .lock_grant   (lock_grant[c]),
            .lock_rel     (lock_rel[c]),
            .done_req     (done_req[c]),
            .cur_dst      (cur_dst[c]),
            .ch_busy      (ch_busy[c]),
            .perf_stall   (perf_stall[c])
        );
    end

    // Lowest channel index claims a free loader first; later requesters see it taken.
    always_comb begin
        lock_grant = '0;
        lock_taken = lock_busy;
        for (int c = 0; c < DDR_CH; c++) begin
            if (lock_req[c] && !lock_taken[cur_dst[c]]) begin
                lock_grant[c]           = 1'b1;
                lock_taken[cur_dst[c]]  = 1'b1;
            end
        end
    end

    // Release lands in the register, so a waiting channel is granted the cycle after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_busy  <= '0;
            lock_owner <= '0;
        end else begin
            for (int c = 0; c < DDR_CH; c++) begin
                if (lock_rel[c]) lock_busy[cur_dst[c]] <= 1'b0;
                if (lock_grant[c]) begin
                    lock_busy[cur_dst[c]]  <= 1'b1;
                    lock_owner[cur_dst[c]] <= OWN_W'(c);
                end
            end
        end
    end

    always_comb begin
        ld_valid = '0;
        ld_data  = '0;
        for (int l = 0; l < LD_NUM; l++) begin
            if (lock_busy[l]) begin
                ld_valid[l] = ddr_valid[lock_owner[l]];
                ld_data[l]  = ddr_data[lock_owner[l]];
            end
        end
    end

    always_comb begin
        done_nx = '0;
        for (int c = 0; c < DDR_CH; c++) begin
            if (done_req[c]) done_nx[cur_dst[c]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ld_done <= '0;
        else     ld_done <= done_nx;
    end

endmodule

// File: tb/tb_ddr_route_mux.sv
// Bench for ddr_route_mux: descriptor table plus hand-written arbitration, backpressure,
// reset and stall sequences; loader beats checked against per-loader expectation queues.
module tb_ddr_route_mux;
    import ddr_route_mux_pkg::*;

    localparam int NCH = 2, NLD = 4, DW = 512, BW = 16;

    logic                      clk = 1'b0, rst;
    logic [NCH-1:0]            route_valid, route_ready;
    logic [NCH-1:0][LD_W-1:0]  route_dst;
    logic [NCH-1:0][BW-1:0]    route_beats;
    logic [NCH-1:0][DW-1:0]    ddr_data;
    logic [NCH-1:0]            ddr_valid, ddr_ready;
    logic [NLD-1:0][DW-1:0]    ld_data;
    logic [NLD-1:0]            ld_valid, ld_ready, ld_done;
    logic [NCH-1:0]            ch_busy;
    logic [NCH-1:0][31:0]      perf_stall;

    ddr_route_mux u_dut (
        .clk (clk), .rst (rst),
        .route_valid (route_valid), .route_ready (route_ready),
        .route_dst (route_dst), .route_beats (route_beats),
        .ddr_data (ddr_data), .ddr_valid (ddr_valid), .ddr_ready (ddr_ready),
        .ld_data (ld_data), .ld_valid (ld_valid), .ld_ready (ld_ready),
        .ld_done (ld_done), .ch_busy (ch_busy), .perf_stall (perf_stall)
    );

    always #5 clk = ~clk;

    typedef logic [DW-1:0] beat_t;
    typedef struct {
        int ch; int dst; int beats;
        int exp_vcyc; int exp_done; int exp_rdy;
    } vec_t;

    beat_t          drv_q [NCH][$];
    beat_t          exp_q [NLD][$];
    int             exp_done [NLD], done_cnt [NLD], vcyc [NLD], last_hs [NLD];
    bit             had_beats [NLD];
    int             ch_first [NCH], ch_last [NCH];
    bit             rdy_seen [NCH];
    logic [NCH-1:0] hs_ch, racc;
    int             cyc, n_vec, n_bad;
    vec_t           tbl [6];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic beat_t rnd();
        beat_t r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic apply_drv();
        for (int c = 0; c < NCH; c++) begin
            ddr_valid[c] = (drv_q[c].size() != 0);
            ddr_data[c]  = (drv_q[c].size() != 0) ? drv_q[c][0] : '0;
        end
    endtask

    task automatic monitor();
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            hs_ch[c] = ddr_valid[c] && ddr_ready[c];
            racc[c]  = route_valid[c] && route_ready[c];
            if (ddr_ready[c]) rdy_seen[c] = 1'b1;
            if (hs_ch[c]) begin
                if (ch_first[c] < 0) ch_first[c] = cyc;
                ch_last[c] = cyc;
            end
        end
        for (int l = 0; l < NLD; l++) begin
            if (ld_done[l]) begin
                done_cnt[l]++;
                if (exp_done[l] == 0) chk("stray_done", 1, 0);
                else exp_done[l]--;
                if (had_beats[l]) chk("done_latency", cyc - last_hs[l], 1);
                had_beats[l] = 1'b0;
            end
            if (ld_valid[l]) begin
                vcyc[l]++;
                if (exp_q[l].size() == 0) chk("stray_valid", 1, 0);
                else begin
                    chk("ld_data", ld_data[l], exp_q[l][0]);
                    if (ld_ready[l]) begin
                        void'(exp_q[l].pop_front());
                        last_hs[l]   = cyc;
                        had_beats[l] = 1'b1;
                    end
                end
            end else begin
                chk("idle_data_zero", ld_data[l], '0);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (hs_ch[c]) void'(drv_q[c].pop_front());
            if (racc[c])  route_valid[c] = 1'b0;
        end
        apply_drv();
    endtask

    task automatic push_start(input int c, input int dst, input int beats, input bit stray);
        beat_t d;
        route_valid[c] = 1'b1;
        route_dst[c]   = LD_W'(dst);
        route_beats[c] = BW'(beats);
        for (int i = 0; i < beats; i++) begin
            d = rnd();
            drv_q[c].push_back(d);
            exp_q[dst].push_back(d);
        end
        exp_done[dst]++;
        if (stray) drv_q[c].push_back(rnd());
        apply_drv();
    endtask

    task automatic wait_routes(input string nm);
        int b = 0;
        while (route_valid != '0 && b < 60) begin step(); b++; end
        if (route_valid != '0) begin
            chk({nm, "_accept_timeout"}, 1, 0);
            route_valid = '0;
        end
    endtask

    function automatic bit model_idle();
        if (ch_busy != '0) return 1'b0;
        for (int l = 0; l < NLD; l++)
            if (exp_q[l].size() != 0 || exp_done[l] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string nm);
        int b = 0;
        while (!model_idle() && b < 200) begin step(); b++; end
        if (!model_idle()) chk({nm, "_idle_timeout"}, 1, 0);
    endtask

    task automatic clr_stats();
        for (int l = 0; l < NLD; l++) begin vcyc[l] = 0; done_cnt[l] = 0; end
        for (int c = 0; c < NCH; c++) begin ch_first[c] = -1; ch_last[c] = -1; rdy_seen[c] = 1'b0; end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_route_ready"}, route_ready, {NCH{1'b1}});
        chk({p, "_ddr_ready"},   ddr_ready, 0);
        chk({p, "_ld_valid"},    ld_valid, 0);
        chk({p, "_ld_done"},     ld_done, 0);
        chk({p, "_ld_data"},     (ld_data != '0), 0);
        chk({p, "_ch_busy"},     ch_busy, 0);
        chk({p, "_perf"},        (perf_stall != '0), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
`ifdef ROUTE_PERF_EN
        logic [31:0] p0;
`endif
        tbl[0] = '{0, 2, 4, 4, 1, 1};
        tbl[1] = '{1, 3, 3, 3, 1, 1};
        tbl[2] = '{0, 1, 0, 0, 1, 0};
        tbl[3] = '{1, 0, 1, 1, 1, 1};
        tbl[4] = '{1, 1, 0, 0, 1, 0};
        tbl[5] = '{0, 3, 7, 7, 1, 1};

        n_vec = 0; n_bad = 0; cyc = 0;
        hs_ch = '0; racc = '0;
        for (int l = 0; l < NLD; l++) begin exp_done[l] = 0; had_beats[l] = 1'b0; last_hs[l] = 0; end
        clr_stats();
        rst = 1'b1; route_valid = '0; route_dst = '0; route_beats = '0;
        ddr_valid = '0; ddr_data = '0; ld_ready = '1;
        #12;
        chk_reset("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // single-route table
        for (int i = 0; i < 6; i++) begin
            clr_stats();
            push_start(tbl[i].ch, tbl[i].dst, tbl[i].beats, 1'b1);
            wait_routes("vec");
            wait_idle("vec");
            repeat (3) step();
            chk("vec_valid_cycles", vcyc[tbl[i].dst], tbl[i].exp_vcyc);
            chk("vec_done_count",   done_cnt[tbl[i].dst], tbl[i].exp_done);
            chk("vec_ddr_ready",    rdy_seen[tbl[i].ch], tbl[i].exp_rdy);
            chk("vec_stray_held",   drv_q[tbl[i].ch].size(), 1);
            chk("vec_ch_busy",      ch_busy, 0);
            drv_q[tbl[i].ch].delete();
            apply_drv();
            step();
        end

        // both channels to loader 1: ch0 first, ch1 one bubble after lock release
        clr_stats();
        push_start(0, 1, 3, 1'b0);
        push_start(1, 1, 2, 1'b0);
        wait_routes("t2");
        wait_idle("t2");
        step();
        chk("t2_ch0_beats",   ch_last[0] - ch_first[0], 2);
        chk("t2_ch1_start",   ch_first[1], ch_last[0] + 2);
        chk("t2_done_pulses", done_cnt[1], 2);

        // disjoint loaders stream in parallel
        clr_stats();
        push_start(0, 0, 4, 1'b0);
        push_start(1, 3, 4, 1'b0);
        wait_routes("t3");
        wait_idle("t3");
        step();
        chk("t3_first_same", ch_first[1], ch_first[0]);
        chk("t3_last_same",  ch_last[1], ch_last[0]);
        chk("t3_full_rate",  ch_last[0] - ch_first[0], 3);

        // FIFO fill behind a stalled route, FIFO order
        clr_stats();
        ld_ready[1] = 1'b0;
        push_start(0, 1, 1, 1'b0);
        wait_routes("t4");
        repeat (3) step();
        for (int k = 1; k <= 4; k++) begin
            chk("t4_ready_open", route_ready[0], 1);
            push_start(0, 1, k, 1'b0);
            wait_routes("t4");
        end
        chk("t4_full", route_ready[0], 0);
        push_start(0, 1, 2, 1'b0);
        repeat (4) step();
        chk("t4_held", route_ready[0], 0);
        ld_ready[1] = 1'b1;
        wait_routes("t4");
        wait_idle("t4");
        chk("t4_done_count", done_cnt[1], 6);

        // stall of a streaming channel
        clr_stats();
        ld_ready[3] = 1'b0;
        push_start(0, 3, 1, 1'b0);
        wait_routes("t5");
        b = 0;
        while (vcyc[3] == 0 && b < 20) begin step(); b++; end
        chk("t5_stream_seen", (vcyc[3] != 0), 1);
`ifdef ROUTE_PERF_EN
        p0 = perf_stall[0];
        repeat (10) step();
        chk("t5_perf_delta", perf_stall[0] - p0, 10);
`else
        repeat (10) step();
        chk("t5_perf_zero", (perf_stall != '0), 0);
`endif
        ld_ready[3] = 1'b1;
        wait_idle("t5");

        // reset mid-stream
        clr_stats();
        push_start(0, 2, 6, 1'b0);
        wait_routes("t6");
        b = 0;
        while (drv_q[0].size() > 4 && b < 30) begin step(); b++; end
        chk("t6_two_beats", drv_q[0].size(), 4);
        rst = 1'b1;
        #1;
        chk_reset("t6_rst");
        for (int c = 0; c < NCH; c++) drv_q[c].delete();
        for (int l = 0; l < NLD; l++) begin exp_q[l].delete(); exp_done[l] = 0; had_beats[l] = 1'b0; end
        route_valid = '0;
        apply_drv();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) step();
        chk("t6_no_done", done_cnt[2], 0);
        clr_stats();
        push_start(0, 2, 3, 1'b0);
        wait_routes("t6b");
        wait_idle("t6b");
        step();
        chk("t6_after_valid", vcyc[2], 3);
        chk("t6_after_done",  done_cnt[2], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
